match_tally: RTL and testbench
==============================

Name: match_tally

Overview:
- Downstream consumer of the game-state stage.
- Watches GAMEOVER/WHO, detects each completed match once, and updates saturating win/streak statistics.
- Queues every result in a small history FIFO, drained by a valid/ready read port (display or host logger).
- Sits directly after game_state; does not drive any signal back into the game loop.

Parameters:
- DEPTH, 8, history FIFO entries; power of two, >= 2.
- CNT_W, 8, width of the match, win and streak counters.

Ports:
- clk  input  1  system clock, all logic on posedge
- reset  input  1  asynchronous, active-high; clears all state immediately
- GAMEOVER  input  1  game-over flag from game_state; may stay high for more than one cycle
- WHO  input  2  winner code: 2'b10 = player W, 2'b01 = player L; 00/11 invalid
- tally_clr  input  1  synchronous clear of statistics and FIFO
- rd_ready  input  1  consumer accepts the head entry
- rd_valid  output  1  FIFO non-empty
- rd_who  output  2  WHO of the head entry
- rd_seq  output  CNT_W  match number of the head entry (first match = 1)
- match_count  output  CNT_W  total accepted matches
- w_wins  output  CNT_W  matches won with WHO=10
- l_wins  output  CNT_W  matches won with WHO=01
- streak  output  CNT_W  consecutive wins by streak_who
- streak_who  output  2  holder of the current streak; 00 when none
- fifo_full  output  1  FIFO holds DEPTH entries
- overflow  output  1  sticky: a result was dropped because the FIFO was full
- bad_who  output  1  sticky: a GAMEOVER edge arrived with WHO 00 or 11

Behaviour:
- Reset (async assert):
  - every output and internal register goes to 0, including the FIFO pointers and the GAMEOVER delay register;
  - rd_who and rd_seq read 0 while empty.
- Event detection:
  - go_q registers GAMEOVER each cycle.
  - An event occurs on a cycle where GAMEOVER=1 and go_q=0.
  - A multi-cycle-high GAMEOVER produces exactly one event.
  - WHO is sampled on the same edge as the event.
- Valid event (WHO = 10 or 01), all updated on the event edge:
  - match_count increments;
  - the matching w_wins or l_wins increments;
  - streak: if WHO == streak_who, streak increments; otherwise streak_who <= WHO and streak <= 1;
  - a push of {WHO, match_count+1} into the FIFO is attempted.
- Invalid event (WHO = 00 or 11):
  - sets bad_who;
  - no counter change and no push.
- Saturation:
  - all counters saturate at 2^CNT_W-1 and never wrap;
  - the rd_seq pushed saturates the same way.
- Latency: an entry pushed at edge N is visible (rd_valid=1) after edge N; one-cycle latency.
- FIFO read (first-word fall-through):
  - the head entry is presented while rd_valid=1;
  - a pop happens on an edge with rd_valid && rd_ready;
  - rd_ready while empty has no effect.
- FIFO full:
  - a push while full with no simultaneous pop is dropped and sets overflow;
  - statistics still update.
  - Push and pop on the same edge while full: both succeed and the occupancy stays at DEPTH.
  - Push and pop on the same edge while non-empty: occupancy unchanged.
- tally_clr (synchronous) clears counters, streak, FIFO, overflow and bad_who.
  - It takes priority over an event on the same edge; that event is discarded.
  - go_q still updates normally, so a still-high GAMEOVER does not re-trigger.
- Reset asserted mid-read or mid-event: state clears immediately. After release, a GAMEOVER already high counts as a new event on the first edge, because go_q=0.
- fifo_full and rd_valid are decoded from registered pointers/occupancy; they are not combinational from inputs.

Optional Feature:
- Macro: MATCH_TALLY_TIMESTAMP_EN.
- When defined:
  - a 16-bit free-running cycle counter runs; it is cleared by reset and tally_clr and wraps at 2^16;
  - each pushed entry also stores the counter value at the event edge;
  - a 16-bit rd_stamp output presents the head timestamp (0 when empty).
- When undefined: no counter, no extra storage, no rd_stamp port.

Test Plan:
- Reset release, GAMEOVER held high 3 cycles with WHO=10 -> match_count=1, w_wins=1, streak=1, streak_who=10, one FIFO entry {10, seq 1}.
- Three events WHO=01,01,10, rd_ready=0 -> l_wins=2, w_wins=1, streak=1, streak_who=10; draining with rd_ready=1 yields seq 1,2,3 in order, then rd_valid=0.
- DEPTH+1 events with rd_ready=0 -> fifo_full=1, overflow=1, match_count=9; the last entry is dropped; draining returns seq 1..8.
- FIFO full, event coincident with rd_ready=1 -> pop of seq 1 and push of seq 9 on the same edge; overflow stays 0; occupancy stays 8.
- Event with WHO=11 -> bad_who=1, all counters unchanged, no push; then tally_clr=1 for one cycle -> every output 0.
- CNT_W=2, five consecutive WHO=10 events -> w_wins=3, streak=3, match_count=3 (saturated); async reset asserted between clock edges clears all outputs before the next edge.

Source files
------------

// File: rtl/match_tally_if.sv
// Read-port bundle for match_tally's history FIFO (first-word fall-through, valid/ready).
// MATCH_TALLY_TIMESTAMP_EN adds the rd_stamp head timestamp.
interface match_tally_if #(
  parameter int CNT_W = 8
) ();
  logic             rd_valid;
  logic             rd_ready;
  logic [1:0]       rd_who;
  logic [CNT_W-1:0] rd_seq;
`ifdef MATCH_TALLY_TIMESTAMP_EN
  logic [15:0]      rd_stamp;

  modport master (output rd_valid, output rd_who, output rd_seq, output rd_stamp, input rd_ready);
  modport slave  (input rd_valid, input rd_who, input rd_seq, input rd_stamp, output rd_ready);
`else
  modport master (output rd_valid, output rd_who, output rd_seq, input rd_ready);
  modport slave  (input rd_valid, input rd_who, input rd_seq, output rd_ready);
`endif
endinterface

// File: rtl/match_tally.sv
// Match statistics and result history following game_state: one event per GAMEOVER rise.
// Optional macro MATCH_TALLY_TIMESTAMP_EN stores a 16-bit cycle stamp with each history entry.
module match_tally #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             GAMEOVER,
  input  logic [1:0]       WHO,
  input  logic             tally_clr,
  match_tally_if.master    rd,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] w_wins,
  output logic [CNT_W-1:0] l_wins,
  output logic [CNT_W-1:0] streak,
  output logic [1:0]       streak_who,
  output logic             fifo_full,
  output logic             overflow,
  output logic             bad_who
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  logic             go_q, go_d;
  logic [CNT_W-1:0] match_count_q, match_count_d;
  logic [CNT_W-1:0] w_wins_q, w_wins_d;
  logic [CNT_W-1:0] l_wins_q, l_wins_d;
  logic [CNT_W-1:0] streak_q, streak_d;
  logic [1:0]       streak_who_q, streak_who_d;
  logic             overflow_q, overflow_d;
  logic             bad_who_q, bad_who_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]    count_q, count_d;
  logic [1:0]       mem_who_q [DEPTH];
  logic [1:0]       mem_who_d [DEPTH];
  logic [CNT_W-1:0] mem_seq_q [DEPTH];
  logic [CNT_W-1:0] mem_seq_d [DEPTH];
`ifdef MATCH_TALLY_TIMESTAMP_EN
  logic [15:0]      stamp_q, stamp_d;
  logic [15:0]      mem_stamp_q [DEPTH];
  logic [15:0]      mem_stamp_d [DEPTH];
`endif

  logic event_s, who_ok_s, pop_s, push_s, full_s, rd_valid_s;

  assign full_s     = (count_q == DEPTH_C);
  assign rd_valid_s = (count_q != {OW{1'b0}});

  // Event detection, statistics update and FIFO push/pop bookkeeping.
  always_comb begin
    go_d          = GAMEOVER;
    match_count_d = match_count_q;
    w_wins_d      = w_wins_q;
    l_wins_d      = l_wins_q;
    streak_d      = streak_q;
    streak_who_d  = streak_who_q;
    overflow_d    = overflow_q;
    bad_who_d     = bad_who_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    mem_who_d     = mem_who_q;
    mem_seq_d     = mem_seq_q;
`ifdef MATCH_TALLY_TIMESTAMP_EN
    mem_stamp_d   = mem_stamp_q;
    stamp_d       = stamp_q + 16'd1;
`endif

    event_s  = GAMEOVER & ~go_q;
    who_ok_s = (WHO == 2'b10) | (WHO == 2'b01);
    pop_s    = rd_valid_s & rd.rd_ready;
    push_s   = event_s & who_ok_s & (~full_s | pop_s);

    if (tally_clr) begin
      // Clear wins over any coincident event; go_d still tracks GAMEOVER.
      match_count_d = {CNT_W{1'b0}};
      w_wins_d      = {CNT_W{1'b0}};
      l_wins_d      = {CNT_W{1'b0}};
      streak_d      = {CNT_W{1'b0}};
      streak_who_d  = 2'b00;
      overflow_d    = 1'b0;
      bad_who_d     = 1'b0;
      wr_ptr_d      = {AW{1'b0}};
      rd_ptr_d      = {AW{1'b0}};
      count_d       = {OW{1'b0}};
`ifdef MATCH_TALLY_TIMESTAMP_EN
      stamp_d       = 16'd0;
`endif
    end else begin
      if (event_s && who_ok_s) begin
        match_count_d = sat_inc(match_count_q);
        case (WHO)
          2'b10:   w_wins_d = sat_inc(w_wins_q);
          2'b01:   l_wins_d = sat_inc(l_wins_q);
          default: w_wins_d = w_wins_q;
        endcase
        if (WHO == streak_who_q) begin
          streak_d = sat_inc(streak_q);
        end else begin
          streak_who_d = WHO;
          streak_d     = CNT_W'(1);
        end
        if (push_s) begin
          mem_who_d[wr_ptr_q] = WHO;
          mem_seq_d[wr_ptr_q] = sat_inc(match_count_q);
`ifdef MATCH_TALLY_TIMESTAMP_EN
          mem_stamp_d[wr_ptr_q] = stamp_q;
`endif
          wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
          overflow_d = 1'b1;
        end
      end else if (event_s) begin
        bad_who_d = 1'b1;
      end else begin
        bad_who_d = bad_who_q;
      end

      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
        2'b10:   count_d = count_q + OW'(1);
        2'b01:   count_d = count_q - OW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; async reset clears everything including the history storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      go_q          <= 1'b0;
      match_count_q <= {CNT_W{1'b0}};
      w_wins_q      <= {CNT_W{1'b0}};
      l_wins_q      <= {CNT_W{1'b0}};
      streak_q      <= {CNT_W{1'b0}};
      streak_who_q  <= 2'b00;
      overflow_q    <= 1'b0;
      bad_who_q     <= 1'b0;
      wr_ptr_q      <= {AW{1'b0}};
      rd_ptr_q      <= {AW{1'b0}};
      count_q       <= {OW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_who_q[i] <= 2'b00;
        mem_seq_q[i] <= {CNT_W{1'b0}};
`ifdef MATCH_TALLY_TIMESTAMP_EN
        mem_stamp_q[i] <= 16'd0;
`endif
      end
`ifdef MATCH_TALLY_TIMESTAMP_EN
      stamp_q       <= 16'd0;
`endif
    end else begin
      go_q          <= go_d;
      match_count_q <= match_count_d;
      w_wins_q      <= w_wins_d;
      l_wins_q      <= l_wins_d;
      streak_q      <= streak_d;
      streak_who_q  <= streak_who_d;
      overflow_q    <= overflow_d;
      bad_who_q     <= bad_who_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      mem_who_q     <= mem_who_d;
      mem_seq_q     <= mem_seq_d;
`ifdef MATCH_TALLY_TIMESTAMP_EN
      mem_stamp_q   <= mem_stamp_d;
      stamp_q       <= stamp_d;
`endif
    end
  end

  // Head-of-FIFO presentation; zeros while empty.
  always_comb begin
    rd.rd_valid = rd_valid_s;
    if (rd_valid_s) begin
      rd.rd_who = mem_who_q[rd_ptr_q];
      rd.rd_seq = mem_seq_q[rd_ptr_q];
    end else begin
      rd.rd_who = 2'b00;
      rd.rd_seq = {CNT_W{1'b0}};
    end
`ifdef MATCH_TALLY_TIMESTAMP_EN
    if (rd_valid_s) begin
      rd.rd_stamp = mem_stamp_q[rd_ptr_q];
    end else begin
      rd.rd_stamp = 16'd0;
    end
`endif
  end

  assign match_count = match_count_q;
  assign w_wins      = w_wins_q;
  assign l_wins      = l_wins_q;
  assign streak      = streak_q;
  assign streak_who  = streak_who_q;
  assign fifo_full   = full_s;
  assign overflow    = overflow_q;
  assign bad_who     = bad_who_q;

endmodule

// File: tb/tb_match_tally.sv
// Randomised and directed bench for match_tally: an 8-bit and a 2-bit counter instance share
// stimulus and are checked every cycle against an unbounded queue-based model clipped to width.
module tb_match_tally;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       GAMEOVER;
  logic [1:0] WHO;
  logic       tally_clr;
  logic       rd_ready_s;

  logic [7:0] mc_a, ww_a, lw_a, st_a;
  logic [1:0] sw_a;
  logic       full_a, ovf_a, bad_a;
  logic [1:0] mc_b, ww_b, lw_b, st_b;
  logic [1:0] sw_b;
  logic       full_b, ovf_b, bad_b;

  match_tally_if #(.CNT_W(8)) rd_a ();
  match_tally_if #(.CNT_W(2)) rd_b ();
  assign rd_a.rd_ready = rd_ready_s;
  assign rd_b.rd_ready = rd_ready_s;

  match_tally #(.DEPTH(DEPTH), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .GAMEOVER(GAMEOVER), .WHO(WHO), .tally_clr(tally_clr),
    .rd(rd_a.master), .match_count(mc_a), .w_wins(ww_a), .l_wins(lw_a), .streak(st_a),
    .streak_who(sw_a), .fifo_full(full_a), .overflow(ovf_a), .bad_who(bad_a));

  match_tally #(.DEPTH(DEPTH), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .GAMEOVER(GAMEOVER), .WHO(WHO), .tally_clr(tally_clr),
    .rd(rd_b.master), .match_count(mc_b), .w_wins(ww_b), .l_wins(lw_b), .streak(st_b),
    .streak_who(sw_b), .fifo_full(full_b), .overflow(ovf_b), .bad_who(bad_b));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Unbounded reference state; each DUT sees it clipped to its counter width.
  int m_mc, m_ww, m_lw, m_st, m_sw;
  bit m_ovf, m_bad, m_go;
  int q_who[$];
  int q_seq[$];

  function automatic int sat(int v, int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear_stats();
    m_mc = 0; m_ww = 0; m_lw = 0; m_st = 0; m_sw = 0;
    m_ovf = 1'b0; m_bad = 1'b0;
    q_who.delete();
    q_seq.delete();
  endtask

  task automatic set_reset(input logic v);
    reset = v;
    if (v) begin
      model_clear_stats();
      m_go = 1'b0;
    end
  endtask

  task automatic model_step();
    bit ev, pop;
    int occ;
    if (reset) begin
      model_clear_stats();
      m_go = 1'b0;
    end else begin
      ev   = GAMEOVER && !m_go;
      m_go = GAMEOVER;
      occ  = q_who.size();
      pop  = (occ > 0) && rd_ready_s;
      if (tally_clr) begin
        model_clear_stats();
      end else begin
        if (pop) begin
          void'(q_who.pop_front());
          void'(q_seq.pop_front());
        end
        if (ev && (WHO == 2'b10 || WHO == 2'b01)) begin
          m_mc++;
          if (WHO == 2'b10) m_ww++;
          else m_lw++;
          if (int'(WHO) == m_sw) m_st++;
          else begin
            m_sw = int'(WHO);
            m_st = 1;
          end
          if (occ < DEPTH || pop) begin
            q_who.push_back(int'(WHO));
            q_seq.push_back(m_mc);
          end else begin
            m_ovf = 1'b1;
          end
        end else if (ev) begin
          m_bad = 1'b1;
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic game(input logic [1:0] w);
    GAMEOVER = 1'b1;
    WHO = w;
    cyc();
    GAMEOVER = 1'b0;
    cyc();
  endtask

  task automatic clr();
    tally_clr = 1'b1;
    cyc();
    tally_clr = 1'b0;
  endtask

  // Per-cycle comparison of both instances against the model, on the falling edge.
  always @(negedge clk) begin
    int hw, hs;
    hw = (q_who.size() > 0) ? q_who[0] : 0;
    hs = (q_seq.size() > 0) ? q_seq[0] : 0;
    chk("a.rd_valid",    int'(rd_a.rd_valid), (q_who.size() > 0) ? 1 : 0);
    chk("a.rd_who",      int'(rd_a.rd_who), hw);
    chk("a.rd_seq",      int'(rd_a.rd_seq), sat(hs, 8));
    chk("a.match_count", int'(mc_a), sat(m_mc, 8));
    chk("a.w_wins",      int'(ww_a), sat(m_ww, 8));
    chk("a.l_wins",      int'(lw_a), sat(m_lw, 8));
    chk("a.streak",      int'(st_a), sat(m_st, 8));
    chk("a.streak_who",  int'(sw_a), m_sw);
    chk("a.fifo_full",   int'(full_a), (q_who.size() == DEPTH) ? 1 : 0);
    chk("a.overflow",    int'(ovf_a), int'(m_ovf));
    chk("a.bad_who",     int'(bad_a), int'(m_bad));
    chk("b.rd_valid",    int'(rd_b.rd_valid), (q_who.size() > 0) ? 1 : 0);
    chk("b.rd_who",      int'(rd_b.rd_who), hw);
    chk("b.rd_seq",      int'(rd_b.rd_seq), sat(hs, 2));
    chk("b.match_count", int'(mc_b), sat(m_mc, 2));
    chk("b.w_wins",      int'(ww_b), sat(m_ww, 2));
    chk("b.l_wins",      int'(lw_b), sat(m_lw, 2));
    chk("b.streak",      int'(st_b), sat(m_st, 2));
    chk("b.streak_who",  int'(sw_b), m_sw);
    chk("b.fifo_full",   int'(full_b), (q_who.size() == DEPTH) ? 1 : 0);
    chk("b.overflow",    int'(ovf_b), int'(m_ovf));
    chk("b.bad_who",     int'(bad_b), int'(m_bad));
  end

  initial begin
    GAMEOVER = 1'b0; WHO = 2'b00; tally_clr = 1'b0; rd_ready_s = 1'b0;
    m_go = 1'b0;
    model_clear_stats();
    set_reset(1'b1);
    cyc(); cyc();
    chk("reset.match_count", int'(mc_a), 0);
    chk("reset.rd_valid", int'(rd_a.rd_valid), 0);
    set_reset(1'b0);

    // GAMEOVER held high three cycles counts once.
    GAMEOVER = 1'b1; WHO = 2'b10;
    cyc(); cyc(); cyc();
    GAMEOVER = 1'b0;
    cyc();
    chk("hold.match_count", int'(mc_a), 1);
    chk("hold.w_wins", int'(ww_a), 1);
    chk("hold.streak", int'(st_a), 1);
    chk("hold.streak_who", int'(sw_a), 2);
    chk("hold.rd_who", int'(rd_a.rd_who), 2);
    chk("hold.rd_seq", int'(rd_a.rd_seq), 1);

    // Three results, then in-order drain.
    clr();
    game(2'b01); game(2'b01); game(2'b10);
    chk("three.l_wins", int'(lw_a), 2);
    chk("three.w_wins", int'(ww_a), 1);
    chk("three.streak", int'(st_a), 1);
    chk("three.streak_who", int'(sw_a), 2);
    rd_ready_s = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      chk("drain3.rd_seq", int'(rd_a.rd_seq), i);
      cyc();
    end
    chk("drain3.empty", int'(rd_a.rd_valid), 0);
    rd_ready_s = 1'b0;

    // Overfill by one.
    clr();
    for (int i = 0; i < DEPTH + 1; i++) game(2'b01);
    chk("over.fifo_full", int'(full_a), 1);
    chk("over.overflow", int'(ovf_a), 1);
    chk("over.match_count", int'(mc_a), 9);
    rd_ready_s = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      chk("drain8.rd_seq", int'(rd_a.rd_seq), i);
      cyc();
    end
    chk("drain8.empty", int'(rd_a.rd_valid), 0);
    rd_ready_s = 1'b0;

    // Full FIFO, push and pop on the same edge.
    clr();
    for (int i = 0; i < DEPTH; i++) game(2'b10);
    GAMEOVER = 1'b1; WHO = 2'b10; rd_ready_s = 1'b1;
    cyc();
    GAMEOVER = 1'b0; rd_ready_s = 1'b0;
    cyc();
    chk("pp.overflow", int'(ovf_a), 0);
    chk("pp.fifo_full", int'(full_a), 1);
    chk("pp.rd_seq", int'(rd_a.rd_seq), 2);
    chk("pp.match_count", int'(mc_a), 9);

    // Invalid winner code, then clear.
    game(2'b11);
    chk("bad.bad_who", int'(bad_a), 1);
    chk("bad.match_count", int'(mc_a), 9);
    clr();
    chk("clr.match_count", int'(mc_a), 0);
    chk("clr.rd_valid", int'(rd_a.rd_valid), 0);
    chk("clr.bad_who", int'(bad_a), 0);
    chk("clr.streak_who", int'(sw_a), 0);

    // Event coincident with clear is discarded; still-high GAMEOVER does not re-trigger.
    GAMEOVER = 1'b1; WHO = 2'b01; tally_clr = 1'b1;
    cyc();
    tally_clr = 1'b0;
    cyc();
    GAMEOVER = 1'b0;
    cyc();
    chk("clrev.match_count", int'(mc_a), 0);

    // Saturation on the 2-bit instance, then async reset between edges.
    for (int i = 0; i < 5; i++) game(2'b10);
    chk("sat.w_wins", int'(ww_b), 3);
    chk("sat.streak", int'(st_b), 3);
    chk("sat.match_count", int'(mc_b), 3);
    chk("sat.rd_seq_tail", int'(mc_a), 5);
    #2;
    set_reset(1'b1);
    #1;
    chk("arst.match_count", int'(mc_a), 0);
    chk("arst.w_wins_b", int'(ww_b), 0);
    chk("arst.rd_valid", int'(rd_a.rd_valid), 0);
    GAMEOVER = 1'b1; WHO = 2'b01;
    cyc();
    set_reset(1'b0);
    cyc();
    chk("postrst.match_count", int'(mc_a), 1);
    chk("postrst.l_wins", int'(lw_a), 1);
    GAMEOVER = 1'b0;
    cyc();

    // Randomised traffic.
    for (int it = 0; it < 3000; it++) begin
      int r;
      GAMEOVER = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 7);
      WHO = (r < 3) ? 2'b10 : (r < 6) ? 2'b01 : (r == 6) ? 2'b00 : 2'b11;
      rd_ready_s = ($urandom_range(0, 3) == 0);
      tally_clr = ($urandom_range(0, 99) == 0) || (m_mc > 200);
      if (reset) begin
        set_reset(1'b0);
      end else if ($urandom_range(0, 299) == 0) begin
        #2;
        set_reset(1'b1);
      end
      cyc();
    end
    set_reset(1'b0);
    tally_clr = 1'b0; GAMEOVER = 1'b0; rd_ready_s = 1'b0;
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
